// File: rtl/ahbl_sram_slave.sv
// AHB-Lite single-master SRAM responder: byte/halfword/word little-endian access,
// parameterised wait states, two-cycle ERROR response for misaligned/out-of-range/oversize transfers.
module ahbl_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic                  hmastlock_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [DATA_WIDTH-1:0] hrdata_o
);

    localparam int         IDX_W = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS    = WAIT_STATES[2:0];

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t                r_state, w_state_next;
    logic [2:0]            r_cnt, w_cnt_next;
    logic [IDX_W+1:0]      r_addr;
    logic [1:0]            r_size;
    logic                  r_write;

    logic                  w_ready, w_accept, w_illegal, w_commit;
    logic [3:0]            w_be;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic [DATA_WIDTH-1:0] w_fwd;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_unused_ok;

    assign w_unused_ok = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

    // Anything above the top word index is out of range.
    assign w_illegal = (hsize_i > 3'b010)
                    || ((hsize_i == 3'b001) && haddr_i[0])
                    || ((hsize_i == 3'b010) && (haddr_i[1:0] != 2'b00))
                    || (|haddr_i[ADDR_WIDTH-1:IDX_W+2]);

    assign w_ready  = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign w_accept = hsel_i && htrans_i[1] && hready_i && w_ready;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr  <= haddr_i[IDX_W+1:0];
                r_size  <= hsize_i[1:0];
                r_write <= hwrite_i;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_next = S_LAST;
            end
            S_ERR1: w_state_next = S_ERR2;
            default: begin
                w_state_next = S_IDLE;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_state_next = S_ERR1;
                    end else if (WS == 3'd0) begin
                        w_state_next = S_LAST;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = WS;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00:   w_be = 4'b0001 << r_addr[1:0];
            2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_commit = (r_state == S_LAST) && r_write && !sys_rst_i;
    assign w_wr_idx = r_addr[IDX_W+1:2];
    // With zero wait states the read is launched straight from the address phase.
    assign w_rd_idx = w_accept ? haddr_i[IDX_W+1:2] : r_addr[IDX_W+1:2];

    // Bytes being committed this edge are forwarded so a back-to-back read sees them.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_fwd[8*gi +: 8] = (w_commit && w_be[gi] && (w_wr_idx == w_rd_idx))
                                ? hwdata_i[8*gi +: 8] : r_mem[w_rd_idx][8*gi +: 8];
    end

    always_ff @(posedge sys_clk_i) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_wr_idx][8*b +: 8] <= hwdata_i[8*b +: 8];
            end
        end
        r_rdata <= w_fwd;
    end

    assign hreadyout_o = w_ready;
    assign hresp_o     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign hrdata_o    = ((r_state == S_LAST) && !r_write) ? r_rdata : '0;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench: one instance with zero wait states and one with three, sharing the bus stimulus.
module tb_ahbl_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b000;
    logic [31:0] hwdata = '0;
    logic        tgt = 1'b0;

    logic        ro0, ro3, resp0, resp3;
    logic [31:0] rd0, rd3;
    logic        hready, cur_ro, cur_resp;
    logic [31:0] cur_rdata;

    assign hready    = tgt ? ro3 : ro0;
    assign cur_ro    = hready;
    assign cur_resp  = tgt ? resp3 : resp0;
    assign cur_rdata = tgt ? rd3 : rd0;

    always #5 clk = ~clk;

    ahbl_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .sys_clk_i(clk), .sys_rst_i(rst), .hsel_i(hsel & ~tgt), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000),
        .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(hready),
        .hreadyout_o(ro0), .hresp_o(resp0), .hrdata_o(rd0));

    ahbl_sram_slave #(.WAIT_STATES(3)) u_dut3 (
        .sys_clk_i(clk), .sys_rst_i(rst), .hsel_i(hsel & tgt), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000),
        .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(hready),
        .hreadyout_o(ro3), .hresp_o(resp3), .hrdata_o(rd3));

    int n_vec  = 0;
    int n_miss = 0;

    logic        t_wr    [8];
    logic [31:0] t_addr  [8];
    logic [2:0]  t_size  [8];
    logic [31:0] t_wdata [8];
    logic [31:0] t_exp   [8];
    logic        t_err   [8];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_x(input int i, input logic wr, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] wd, input logic [31:0] ex, input logic er);
        t_wr[i] = wr; t_addr[i] = a; t_size[i] = s; t_wdata[i] = wd; t_exp[i] = ex; t_err[i] = er;
    endtask

    task automatic drive_addr(input int i, input int n);
        if (i < n) begin
            hsel = 1'b1; htrans = 2'b10; haddr = t_addr[i]; hwrite = t_wr[i]; hsize = t_size[i];
        end else begin
            hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'b000;
        end
    endtask

    // Issues n table entries back to back; each address phase overlaps the previous data phase.
    task automatic run(input string name, input int n, input int ws);
        int waits;
        @(posedge clk); #1;
        drive_addr(0, n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            hwdata = t_wdata[i];
            drive_addr(i + 1, n);
            waits = 0;
            while (!cur_ro && waits < 16) begin
                check($sformatf("%s[%0d] stall_resp", name, i), {31'd0, cur_resp}, {31'd0, t_err[i]});
                waits++;
                @(posedge clk); #1;
            end
            check($sformatf("%s[%0d] resp", name, i), {31'd0, cur_resp}, {31'd0, t_err[i]});
            check($sformatf("%s[%0d] waits", name, i), waits, t_err[i] ? 32'd1 : ws);
            check($sformatf("%s[%0d] rdata", name, i), cur_rdata,
                  (t_wr[i] || t_err[i]) ? 32'd0 : t_exp[i]);
            $display("xfer %s[%0d] %s addr=0x%08h size=%0d wdata=0x%08h rdata=0x%08h resp=%0b waits=%0d",
                     name, i, t_wr[i] ? "W" : "R", t_addr[i], t_size[i], t_wdata[i],
                     cur_rdata, cur_resp, waits);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset ro0", {31'd0, ro0}, 32'd1);
        check("reset resp0", {31'd0, resp0}, 32'd0);
        check("reset rd0", rd0, 32'd0);
        check("reset ro3", {31'd0, ro3}, 32'd1);
        check("reset rd3", rd3, 32'd0);
        rst = 1'b0;

        tgt = 1'b0;
        set_x(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
        set_x(1, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
        run("basic", 2, 0);

        set_x(0, 1, 32'h20, 3'b010, 32'h11223344, 32'h0, 0);
        set_x(1, 1, 32'h22, 3'b000, 32'h00AA0000, 32'h0, 0);
        set_x(2, 1, 32'h20, 3'b001, 32'h00005566, 32'h0, 0);
        set_x(3, 0, 32'h20, 3'b010, 32'h0, 32'h11AA5566, 0);
        run("lanes", 4, 0);

        set_x(0, 1, 32'h0000, 3'b010, 32'hCAFEF00D, 32'h0, 0);
        set_x(1, 1, 32'h0002, 3'b010, 32'hFFFFFFFF, 32'h0, 1);
        set_x(2, 1, 32'h0001, 3'b001, 32'hFFFFFFFF, 32'h0, 1);
        set_x(3, 1, 32'h4000, 3'b010, 32'hFFFFFFFF, 32'h0, 1);
        set_x(4, 1, 32'h0000, 3'b011, 32'hFFFFFFFF, 32'h0, 1);
        set_x(5, 0, 32'h4000, 3'b010, 32'h0, 32'h0, 1);
        set_x(6, 0, 32'h0000, 3'b010, 32'h0, 32'hCAFEF00D, 0);
        run("err", 7, 0);

        set_x(0, 1, 32'h30, 3'b010, 32'h00000001, 32'h0, 0);
        set_x(1, 0, 32'h30, 3'b010, 32'h0, 32'h00000001, 0);
        set_x(2, 1, 32'h30, 3'b010, 32'h00000002, 32'h0, 0);
        set_x(3, 0, 32'h30, 3'b010, 32'h0, 32'h00000002, 0);
        run("pipe", 4, 0);

        tgt = 1'b1;
        set_x(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
        set_x(1, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
        set_x(2, 0, 32'h10, 3'b001, 32'h0, 32'hDEADBEEF, 0);
        run("ws3", 3, 3);

        // Reset in the middle of a wait-stated write must abort it.
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'h12345678;
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'b000;
        check("rst_mid wait_ro", {31'd0, ro3}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid ro", {31'd0, ro3}, 32'd1);
        check("rst_mid resp", {31'd0, resp3}, 32'd0);
        check("rst_mid rdata", rd3, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_x(0, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
        run("rst_rb", 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
